or10_multiplier_controller: RTL and testbench

Sequences the external 33x33 multiplier for the OR10 execute stage when ENABLE_EXTERNAL_MULTIPLIER == 1. It accepts one 32-bit multiply request at a time from the ALU, sign- or zero-extends the operands to 33 bits and holds them stable on the multiplier inputs for the multiplier's fixed pipeline latency. It then captures the 64-bit product, computes the OR1K 32-bit overflow flag and signals completion. It also supports abort on pipeline flush, and drives zero operands whenever idle.

---
 rtl/or10_multiplier_controller.sv | 99 +++++++++
 tb/tb_or10_multiplier_controller.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/or10_multiplier_controller.sv
// rtl/or10_multiplier_controller.sv - sequencer for the external 33x33 multiplier of the OR10 execute stage
module or10_multiplier_controller #(
   parameter int MUL_LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] operand_a,
   input  logic [31:0] operand_b,
   input  logic        kill,
   output logic        busy,
   output logic        done,
   output logic [31:0] result_lo,
   output logic [31:0] result_hi,
   output logic        overflow,
   output logic [32:0] mul_a,
   output logic [32:0] mul_b,
   input  logic [65:0] mul_p
);

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t     state;
   logic [3:0] cnt;
   logic       signed_q;
   logic       ovf_next;

   // The top two product bits are redundant for an exact 33x33 product of
   // extended 32-bit operands, so only their presence on the port is kept.
   logic unused_mul_p_top;
   assign unused_mul_p_top = ^mul_p[65:64];

   assign busy = (state == WAIT);

   // Overflow flag for the product currently on mul_p, using the captured signedness
   always_comb begin
      ovf_next = 1'b0;
      if (signed_q) begin
         ovf_next = !((&mul_p[63:31]) || !(|mul_p[63:31]));
      end else begin
         ovf_next = |mul_p[63:32];
      end
   end

   // Request acceptance, latency countdown, product capture and abort handling
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= 4'd0;
         signed_q  <= 1'b0;
         done      <= 1'b0;
         result_lo <= 32'd0;
         result_hi <= 32'd0;
         overflow  <= 1'b0;
         mul_a     <= 33'd0;
         mul_b     <= 33'd0;
      end else if (kill) begin
         state <= IDLE;
         cnt   <= 4'd0;
         done  <= 1'b0;
         mul_a <= 33'd0;
         mul_b <= 33'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  mul_a    <= is_signed ? {operand_a[31], operand_a} : {1'b0, operand_a};
                  mul_b    <= is_signed ? {operand_b[31], operand_b} : {1'b0, operand_b};
                  signed_q <= is_signed;
                  cnt      <= 4'(MUL_LATENCY);
                  state    <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != 4'd0) begin
                  cnt <= cnt - 4'd1;
               end else begin
                  result_lo <= mul_p[31:0];
                  result_hi <= mul_p[63:32];
                  overflow  <= ovf_next;
                  done      <= 1'b1;
                  mul_a     <= 33'd0;
                  mul_b     <= 33'd0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_or10_multiplier_controller.sv
// tb/tb_or10_multiplier_controller.sv - directed self-checking bench for or10_multiplier_controller
module tb_or10_multiplier_controller;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        is_signed = 1'b0;
   logic [31:0] op_a = 32'd0;
   logic [31:0] op_b = 32'd0;

   logic        start2 = 1'b0, kill2 = 1'b0;
   logic        start0 = 1'b0, kill0 = 1'b0;
   logic        start4 = 1'b0, kill4 = 1'b0;

   logic        busy2, done2, ovf2, busy0, done0, ovf0, busy4, done4, ovf4;
   logic [31:0] lo2, hi2, lo0, hi0, lo4, hi4;
   logic [32:0] mul_a2, mul_b2, mul_a0, mul_b0, mul_a4, mul_b4;
   logic [65:0] mul_p2, mul_p0, mul_p4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // Behavioural signed 33x33 multipliers with 2, 0 and 4 register stages
   logic signed [65:0] pr2, pr0, pr4;
   logic [65:0] s2 [0:1];
   logic [65:0] s4 [0:3];
   assign pr2 = $signed(mul_a2) * $signed(mul_b2);
   assign pr0 = $signed(mul_a0) * $signed(mul_b0);
   assign pr4 = $signed(mul_a4) * $signed(mul_b4);
   assign mul_p2 = s2[1];
   assign mul_p0 = pr0;
   assign mul_p4 = s4[3];

   // Advance the multiplier model pipelines
   always @(posedge clk) begin
      s2[0] <= pr2;
      s2[1] <= s2[0];
      s4[0] <= pr4;
      s4[1] <= s4[0];
      s4[2] <= s4[1];
      s4[3] <= s4[2];
   end

   or10_multiplier_controller #(.MUL_LATENCY(2)) dut2 (
      .clk(clk), .reset(reset), .start(start2), .is_signed(is_signed),
      .operand_a(op_a), .operand_b(op_b), .kill(kill2), .busy(busy2), .done(done2),
      .result_lo(lo2), .result_hi(hi2), .overflow(ovf2),
      .mul_a(mul_a2), .mul_b(mul_b2), .mul_p(mul_p2));

   or10_multiplier_controller #(.MUL_LATENCY(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .is_signed(is_signed),
      .operand_a(op_a), .operand_b(op_b), .kill(kill0), .busy(busy0), .done(done0),
      .result_lo(lo0), .result_hi(hi0), .overflow(ovf0),
      .mul_a(mul_a0), .mul_b(mul_b0), .mul_p(mul_p0));

   or10_multiplier_controller #(.MUL_LATENCY(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .is_signed(is_signed),
      .operand_a(op_a), .operand_b(op_b), .kill(kill4), .busy(busy4), .done(done4),
      .result_lo(lo4), .result_hi(hi4), .overflow(ovf4),
      .mul_a(mul_a4), .mul_b(mul_b4), .mul_p(mul_p4));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_b(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One complete operation on the latency-2 instance; reports edges from accept to done
   task automatic run2(input logic sgn, input logic [31:0] a, input logic [31:0] b, output int n);
      is_signed = sgn;
      op_a = a;
      op_b = b;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 20) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;

      // Reset state
      #12;
      chk_b("rst_busy", busy2, 1'b0);
      chk_b("rst_done", done2, 1'b0);
      chk_w("rst_lo", lo2, 32'h0);
      chk_w("rst_hi", hi2, 32'h0);
      chk_b("rst_ovf", ovf2, 1'b0);
      chk_a("rst_mul_a", mul_a2, 33'h0);
      chk_a("rst_mul_b", mul_b2, 33'h0);
      reset = 1'b0;
      tick();

      // Unsigned all-ones squared, cycle by cycle
      is_signed = 1'b0;
      op_a = 32'hFFFFFFFF;
      op_b = 32'hFFFFFFFF;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      chk_b("u_e0_busy", busy2, 1'b1);
      chk_a("u_e0_mul_a", mul_a2, 33'h0FFFFFFFF);
      chk_a("u_e0_mul_b", mul_b2, 33'h0FFFFFFFF);
      tick();
      chk_a("u_e1_mul_a", mul_a2, 33'h0FFFFFFFF);
      chk_b("u_e1_done", done2, 1'b0);
      tick();
      chk_b("u_e2_busy", busy2, 1'b1);
      chk_b("u_e2_done", done2, 1'b0);
      tick();
      chk_b("u_e3_done", done2, 1'b1);
      chk_b("u_e3_busy", busy2, 1'b0);
      chk_w("u_hi", hi2, 32'hFFFFFFFE);
      chk_w("u_lo", lo2, 32'h00000001);
      chk_b("u_ovf", ovf2, 1'b1);
      chk_a("u_e3_mul_a", mul_a2, 33'h0);
      tick();
      chk_b("u_e4_done", done2, 1'b0);
      chk_w("u_e4_hi_hold", hi2, 32'hFFFFFFFE);

      // Signed -2 x 3
      run2(1'b1, 32'hFFFFFFFE, 32'd3, n);
      chk_i("s1_latency", n, 3);
      chk_w("s1_hi", hi2, 32'hFFFFFFFF);
      chk_w("s1_lo", lo2, 32'hFFFFFFFA);
      chk_b("s1_ovf", ovf2, 1'b0);
      tick();

      // Signed 0x7FFFFFFF x 2
      run2(1'b1, 32'h7FFFFFFF, 32'd2, n);
      chk_i("s2_latency", n, 3);
      chk_w("s2_hi", hi2, 32'h0);
      chk_w("s2_lo", lo2, 32'hFFFFFFFE);
      chk_b("s2_ovf", ovf2, 1'b1);
      tick();

      // Unsigned 0x80000000 x 2 crosses into the high word
      run2(1'b0, 32'h80000000, 32'd2, n);
      chk_w("u2_hi", hi2, 32'h1);
      chk_w("u2_lo", lo2, 32'h0);
      chk_b("u2_ovf", ovf2, 1'b1);
      tick();

      // start held high with changing operands: accepts at E0, E4, E8
      is_signed = 1'b0;
      op_b = 32'd10;
      start2 = 1'b1;
      for (int k = 0; k < 12; k++) begin
         op_a = 32'(k + 1);
         tick();
         chk_b($sformatf("str_busy_%0d", k), busy2, (k % 4) != 3);
         chk_b($sformatf("str_done_%0d", k), done2, (k % 4) == 3);
         if ((k % 4) == 3) begin
            chk_w($sformatf("str_lo_%0d", k), lo2, 32'(10 * (k - 2)));
         end
         if ((k % 4) == 1) begin
            chk_a($sformatf("str_mul_a_%0d", k), mul_a2, 33'(k));
         end
      end
      start2 = 1'b0;
      tick();

      // kill one edge after accepting 5 x 7; results stay at 90
      op_a = 32'd5;
      op_b = 32'd7;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      kill2 = 1'b1;
      tick();
      kill2 = 1'b0;
      chk_b("k1_busy", busy2, 1'b0);
      chk_a("k1_mul_a", mul_a2, 33'h0);
      chk_a("k1_mul_b", mul_b2, 33'h0);
      chk_w("k1_lo", lo2, 32'd90);
      op_a = 32'd6;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      chk_b("k1_restart_busy", busy2, 1'b1);
      chk_b("k1_no_done", done2, 1'b0);
      tick();
      tick();
      tick();
      chk_b("k1_done", done2, 1'b1);
      chk_w("k1_lo_42", lo2, 32'd42);
      tick();

      // kill on the capture edge
      op_a = 32'd3;
      op_b = 32'd3;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      tick();
      tick();
      kill2 = 1'b1;
      tick();
      kill2 = 1'b0;
      chk_b("kc_done", done2, 1'b0);
      chk_b("kc_busy", busy2, 1'b0);
      chk_w("kc_lo", lo2, 32'd42);

      // kill together with start in IDLE
      op_a = 32'd4;
      start2 = 1'b1;
      kill2 = 1'b1;
      tick();
      start2 = 1'b0;
      kill2 = 1'b0;
      chk_b("ks_busy", busy2, 1'b0);
      chk_a("ks_mul_a", mul_a2, 33'h0);
      tick();
      chk_b("ks_done", done2, 1'b0);
      chk_w("ks_lo", lo2, 32'd42);

      // Asynchronous reset between edges during WAIT
      op_a = 32'hFFFFFFFF;
      op_b = 32'd2;
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      chk_b("ar_busy", busy2, 1'b0);
      chk_b("ar_done", done2, 1'b0);
      chk_w("ar_lo", lo2, 32'h0);
      chk_a("ar_mul_a", mul_a2, 33'h0);
      chk_a("ar_mul_b", mul_b2, 33'h0);
      #1;
      reset = 1'b0;
      tick();
      chk_b("ar_after_busy", busy2, 1'b0);
      run2(1'b0, 32'd6, 32'd7, n);
      chk_i("ar_latency", n, 3);
      chk_w("ar_lo_42", lo2, 32'd42);
      chk_w("ar_hi", hi2, 32'h0);
      chk_b("ar_ovf", ovf2, 1'b0);
      tick();

      // Latency 0 instance
      is_signed = 1'b0;
      op_a = 32'hFFFFFFFF;
      op_b = 32'hFFFFFFFF;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      chk_b("l0_busy", busy0, 1'b1);
      n = 0;
      while (!done0 && n < 20) begin
         tick();
         n++;
      end
      chk_i("l0_latency", n, 1);
      chk_w("l0_hi", hi0, 32'hFFFFFFFE);
      chk_w("l0_lo", lo0, 32'h00000001);
      chk_b("l0_ovf", ovf0, 1'b1);
      chk_b("l0_kill_idle", kill0, 1'b0);

      // Latency 4 instance
      start4 = 1'b1;
      tick();
      start4 = 1'b0;
      chk_a("l4_mul_a", mul_a4, 33'h0FFFFFFFF);
      n = 0;
      while (!done4 && n < 20) begin
         tick();
         n++;
      end
      chk_i("l4_latency", n, 5);
      chk_w("l4_hi", hi4, 32'hFFFFFFFE);
      chk_w("l4_lo", lo4, 32'h00000001);
      chk_b("l4_ovf", ovf4, 1'b1);
      chk_b("l4_kill_idle", kill4, 1'b0);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
